// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Brief    : Memory-stage load/store unit. Issues single-outstanding
//            req/gnt/rvalid data-memory accesses from the EX/MEM fields,
//            formats store lanes/byte enables and load results, stalls the
//            pipeline until each access completes, and feeds MEM/WB.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] mem_alu_result,
    input  logic [WIDTH-1:0] mem_reg_data2,
    input  logic [4:0]       mem_rd,
    input  logic [2:0]       mem_funct3,
    input  logic [6:0]       mem_opcode,
    input  logic             mem_reg_wr_en,
    input  logic             mem_mem_to_reg,
    input  logic [1:0]       mem_wb_sel,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [3:0]       dmem_be,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             lsu_stall,
    output logic             lsu_fault,
    output logic [WIDTH-1:0] wb_load_data,
    output logic [WIDTH-1:0] wb_alu_result,
    output logic [4:0]       wb_rd,
    output logic             wb_reg_wr_en,
    output logic             wb_mem_to_reg,
    output logic [1:0]       wb_wb_sel
);

    localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] C_OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD_WAIT = 2'd1,
        S_LOAD_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]       w_off;
    logic [1:0]       w_size;
    logic             w_is_load;
    logic             w_is_store;
    logic             w_memop;
    logic             w_bad_f3;
    logic             w_misalign;
    logic             w_fault;
    logic             w_access;
    logic             w_req;
    logic             w_stall;
    logic [WIDTH-1:0] w_wdata;
    logic [3:0]       w_be;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_load_fmt;
    logic [WIDTH-1:0] r_load_data;

    // Decode of the access held at EX/MEM (stable while stalled).
    assign w_off      = mem_alu_result[1:0];
    assign w_size     = mem_funct3[1:0];
    assign w_is_load  = (mem_opcode == C_OP_LOAD);
    assign w_is_store = (mem_opcode == C_OP_STORE);
    assign w_memop    = w_is_load | w_is_store;
    assign w_bad_f3   = (mem_funct3 == 3'b011) | (mem_funct3 == 3'b110) |
                        (mem_funct3 == 3'b111);
    assign w_misalign = ((w_size == 2'b01) & w_off[0]) |
                        ((w_size == 2'b10) & (w_off != 2'b00));
    assign w_fault    = w_memop & (w_bad_f3 | w_misalign);
    assign w_access   = w_memop & ~w_fault;

    // Store lane replication and byte-enable generation.
    always_comb begin
        w_wdata = mem_reg_data2;
        w_be    = 4'b1111;
        case (w_size)
            2'b00: begin
                w_wdata = {4{mem_reg_data2[7:0]}};
                w_be    = 4'b0001 << w_off;
            end
            2'b01: begin
                w_wdata = {2{mem_reg_data2[15:0]}};
                w_be    = 4'b0011 << w_off;
            end
            default: begin
                w_wdata = mem_reg_data2;
                w_be    = 4'b1111;
            end
        endcase
    end

    // Load result: shift the addressed byte/halfword down, then extend.
    assign w_shifted = dmem_rdata >> {w_off, 3'b000};

    // Sign/zero extension chosen by funct3.
    always_comb begin
        w_load_fmt = w_shifted;
        case (mem_funct3)
            3'b000:  w_load_fmt = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load_fmt = {24'd0, w_shifted[7:0]};
            3'b001:  w_load_fmt = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load_fmt = {16'd0, w_shifted[15:0]};
            default: w_load_fmt = w_shifted;
        endcase
    end

    // Access sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, request and stall. A store retires in its gnt cycle; a load
    // waits for rvalid and then releases the pipeline for one LOAD_DONE cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    w_req   = 1'b1;
                    w_stall = ~(w_is_store & dmem_gnt);
                    if (w_is_load && dmem_gnt) begin
                        w_state_nxt = S_LOAD_WAIT;
                    end
                end
            end
            S_LOAD_WAIT: begin
                w_stall = 1'b1;
                if (dmem_rvalid) begin
                    w_state_nxt = S_LOAD_DONE;
                end
            end
            S_LOAD_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Load result capture; held until the next load response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_data <= '0;
        end else if ((r_state == S_LOAD_WAIT) && dmem_rvalid) begin
            r_load_data <= w_load_fmt;
        end
    end

    assign dmem_req      = w_req & ~rst;
    assign dmem_we       = w_is_store;
    assign dmem_addr     = {mem_alu_result[WIDTH-1:2], 2'b00};
    assign dmem_wdata    = w_wdata;
    assign dmem_be       = w_be;
    assign lsu_stall     = w_stall & ~rst;
    assign lsu_fault     = w_fault & ~rst;
    assign wb_load_data  = r_load_data;
    assign wb_alu_result = mem_alu_result;
    assign wb_rd         = mem_rd;
    assign wb_reg_wr_en  = mem_reg_wr_en & ~lsu_fault;
    assign wb_mem_to_reg = mem_mem_to_reg;
    assign wb_wb_sel     = mem_wb_sel;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Brief    : Self-checking bench for mem_stage_lsu: directed scenarios plus
//            randomized load/store/ALU ops against a byte-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

    localparam logic [6:0] C_LOAD  = 7'b0000011;
    localparam logic [6:0] C_STORE = 7'b0100011;
    localparam logic [6:0] C_ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_reg_data2;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic [6:0]  mem_opcode;
    logic        mem_reg_wr_en;
    logic        mem_mem_to_reg;
    logic [1:0]  mem_wb_sel;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        lsu_stall;
    logic        lsu_fault;
    logic [31:0] wb_load_data;
    logic [31:0] wb_alu_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_wr_en;
    logic        wb_mem_to_reg;
    logic [1:0]  wb_wb_sel;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_load = 32'd0;
    int          stalls;

    always #5 clk = ~clk;

    mem_stage_lsu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .mem_alu_result(mem_alu_result), .mem_reg_data2(mem_reg_data2),
        .mem_rd(mem_rd), .mem_funct3(mem_funct3), .mem_opcode(mem_opcode),
        .mem_reg_wr_en(mem_reg_wr_en), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_wb_sel(mem_wb_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .lsu_stall(lsu_stall), .lsu_fault(lsu_fault),
        .wb_load_data(wb_load_data), .wb_alu_result(wb_alu_result),
        .wb_rd(wb_rd), .wb_reg_wr_en(wb_reg_wr_en),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_wb_sel(wb_wb_sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit ref_fault(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] off);
        int nb;
        nb = nbytes(f3);
        if (op != C_LOAD && op != C_STORE) return 1'b0;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (nb == 2 && (off % 2) != 0) return 1'b1;
        if (nb == 4 && off != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        longint sh, md, v;
        int     nb;
        nb = nbytes(f3);
        sh = longint'({32'd0, w}) / (longint'(1) << (8 * off));
        md = longint'(1) << (8 * nb);
        v  = sh % md;
        if (!f3[2] && nb < 4 && v >= md / 2) v = v - md;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        longint lane;
        int     nb;
        nb   = nbytes(f3);
        lane = longint'({32'd0, d}) % (longint'(1) << (8 * nb));
        if (nb == 1) lane = lane * 64'h01010101;
        else if (nb == 2) lane = lane * 64'h00010001;
        return lane[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] off);
        int m;
        m = ((1 << nbytes(f3)) - 1) << off;
        return m[3:0];
    endfunction

    // Present one op at EX/MEM (called just after a rising edge) and play the
    // memory side: gnt after gd cycles, rvalid rdl cycles after gnt.
    task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [31:0] rdata,
                         input int gd, input int rdl, output int nstall);
        bit         flt;
        bit         wr;
        logic [4:0] rd;
        logic [1:0] sel;
        bit         m2r;
        nstall = 0;
        flt = ref_fault(op, f3, addr[1:0]);
        wr  = 1'($urandom_range(0, 1));
        rd  = 5'($urandom);
        sel = 2'($urandom);
        m2r = 1'($urandom_range(0, 1));
        mem_opcode = op; mem_funct3 = f3; mem_alu_result = addr; mem_reg_data2 = rs2;
        mem_rd = rd; mem_wb_sel = sel; mem_mem_to_reg = m2r; mem_reg_wr_en = wr;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
        if (flt || (op != C_LOAD && op != C_STORE)) begin
            dmem_rvalid = 1'($urandom_range(0, 1));
            #4;
            chk("idle_req", 32'(dmem_req), 32'd0);
            chk("idle_stall", 32'(lsu_stall), 32'd0);
            chk("fault", 32'(lsu_fault), 32'(flt));
            chk("wb_reg_wr_en", 32'(wb_reg_wr_en), 32'(wr & ~flt));
            chk("wb_pass", {wb_alu_result[15:0], 3'd0, wb_rd, 3'd0, wb_mem_to_reg, wb_wb_sel, 2'd0},
                {addr[15:0], 3'd0, rd, 3'd0, m2r, sel, 2'd0});
            chk("load_hold", wb_load_data, exp_load);
            tick();
            dmem_rvalid = 1'b0;
            return;
        end
        for (int c = 0; c <= gd; c++) begin
            dmem_gnt = (c == gd);
            #4;
            chk("req", 32'(dmem_req), 32'd1);
            chk("we", 32'(dmem_we), 32'(op == C_STORE));
            chk("addr", dmem_addr, {addr[31:2], 2'b00});
            chk("stall_req", 32'(lsu_stall), 32'((op == C_LOAD) || (c != gd)));
            chk("wb_reg_wr_en", 32'(wb_reg_wr_en), 32'(wr));
            if (op == C_STORE) begin
                chk("wdata", dmem_wdata, ref_wdata(f3, rs2));
                chk("be", 32'(dmem_be), 32'(ref_be(f3, addr[1:0])));
            end
            if (lsu_stall) nstall++;
            tick();
        end
        dmem_gnt = 1'b0;
        if (op != C_LOAD) return;
        for (int c = 1; c <= rdl; c++) begin
            dmem_rvalid = (c == rdl);
            dmem_rdata  = (c == rdl) ? rdata : $urandom;
            #4;
            chk("wait_req", 32'(dmem_req), 32'd0);
            chk("wait_stall", 32'(lsu_stall), 32'd1);
            if (lsu_stall) nstall++;
            tick();
        end
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
        exp_load    = ref_load(f3, addr[1:0], rdata);
        #4;
        chk("done_stall", 32'(lsu_stall), 32'd0);
        chk("done_req", 32'(dmem_req), 32'd0);
        chk("load_data", wb_load_data, exp_load);
        tick();
    endtask

    initial begin
        // Reset with a load already waiting at EX/MEM.
        rst = 1'b1;
        mem_opcode = C_LOAD; mem_funct3 = 3'b010; mem_alu_result = 32'h0000_0100;
        mem_reg_data2 = 32'd0; mem_rd = 5'd1; mem_reg_wr_en = 1'b1;
        mem_mem_to_reg = 1'b1; mem_wb_sel = 2'd1;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        tick(); tick();
        #4;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(lsu_stall), 32'd0);
        chk("rst_load", wb_load_data, 32'd0);
        mem_alu_result = 32'h0000_0102;
        #1;
        chk("rst_fault", 32'(lsu_fault), 32'd0);
        tick();
        mem_opcode = C_ALU; dmem_gnt = 1'b0;
        rst = 1'b0;
        tick();

        // SB to byte 3 with immediate grant.
        do_op(C_STORE, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'd0, 0, 1, stalls);
        chk("sb_stalls", 32'(stalls), 32'd0);

        // LH at offset 2, gnt after 2 cycles, rvalid 3 cycles later.
        do_op(C_LOAD, 3'b001, 32'h0000_2002, 32'd0, 32'h8001_1234, 2, 3, stalls);
        chk("lh_stalls", 32'(stalls), 32'd6);
        chk("lh_value", exp_load, 32'hFFFF_8001);

        // LBU at offset 1.
        do_op(C_LOAD, 3'b100, 32'h0000_2001, 32'd0, 32'h0000_F200, 1, 1, stalls);
        chk("lbu_value", wb_load_data, 32'h0000_00F2);

        // Misaligned LW.
        do_op(C_LOAD, 3'b010, 32'h0000_3002, 32'd0, 32'd0, 0, 1, stalls);

        // Randomized ops, issued back to back.
        for (int i = 0; i < 80; i++) begin
            logic [6:0]  op;
            int          k;
            k  = $urandom_range(0, 3);
            op = (k < 2) ? C_LOAD : (k == 2) ? C_STORE : C_ALU;
            do_op(op, 3'($urandom), $urandom, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(1, 3), stalls);
        end

        // Guarantee a non-zero held result before the reset-in-flight check.
        do_op(C_LOAD, 3'b010, 32'h0000_4000, 32'd0, 32'h1357_9BDF, 0, 1, stalls);

        // Reset while a load is waiting for its response.
        mem_opcode = C_LOAD; mem_funct3 = 3'b010; mem_alu_result = 32'h0000_5000;
        dmem_gnt = 1'b1;
        #4;
        chk("rw_req", 32'(dmem_req), 32'd1);
        tick();
        dmem_gnt = 1'b0;
        #4;
        chk("rw_wait_stall", 32'(lsu_stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_rst_stall", 32'(lsu_stall), 32'd0);
        chk("rw_rst_load", wb_load_data, 32'd0);
        exp_load = 32'd0;
        tick();
        mem_opcode = C_ALU;
        rst = 1'b0;
        tick();
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #4;
        chk("late_stall", 32'(lsu_stall), 32'd0);
        chk("late_req", 32'(dmem_req), 32'd0);
        tick();
        dmem_rvalid = 1'b0;
        #4;
        chk("late_load", wb_load_data, 32'd0);
        chk("late_stall2", 32'(lsu_stall), 32'd0);
        // A fresh load after reset must still work normally.
        tick();
        do_op(C_LOAD, 3'b000, 32'h0000_6003, 32'd0, 32'h8000_0000, 1, 2, stalls);
        chk("post_rst_lb", wb_load_data, 32'hFFFF_FF80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit sitting directly downstream of the EX/MEM pipeline register. It consumes the registered EX/MEM fields, drives a single-outstanding request/grant/response data-memory port, and formats store data/byte enables and load results. It raises a pipeline stall until each access completes, and presents load data plus pass-through control to the MEM/WB register.

## Interface
- WIDTH, 32, datapath width from all_pkgs; only 32 is supported, and byte enables are WIDTH/8 bits.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_alu_result  in  WIDTH  effective address (loads/stores) or ALU result.
- mem_reg_data2  in  WIDTH  store source (rs2).
- mem_rd  in  5  destination register.
- mem_funct3  in  3  access size/sign.
- mem_opcode  in  7  LOAD = 7'b0000011, STORE = 7'b0100011; anything else is a non-memory op.
- mem_reg_wr_en, mem_mem_to_reg  in  1  control from EX/MEM.
- mem_wb_sel  in  2  writeback select from EX/MEM.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = store.
- dmem_addr  out  WIDTH  word-aligned address {mem_alu_result[31:2], 2'b00}.
- dmem_wdata  out  WIDTH  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load response valid.
- dmem_rdata  in  WIDTH  load response word.
- lsu_stall  out  1  hold IF/ID, ID/EX and EX/MEM; insert a bubble into MEM/WB.
- lsu_fault  out  1  misaligned or illegal-funct3 memory op.
- wb_load_data  out  WIDTH  formatted load result.
- wb_alu_result  out  WIDTH  pass-through of mem_alu_result.
- wb_rd  out  5  pass-through of mem_rd.
- wb_reg_wr_en  out  1  mem_reg_wr_en & ~lsu_fault.
- wb_mem_to_reg  out  1  pass-through of mem_mem_to_reg.
- wb_wb_sel  out  2  pass-through of mem_wb_sel.

## Operation
- Address offset is off = mem_alu_result[1:0].
- Fault: funct3 011, 110 or 111; a halfword with off[0]=1; a word with off≠0.
  - A faulting op issues no request and does not stall.
- States:
  - IDLE: on a non-faulting LOAD/STORE, dmem_req=1 combinationally, held with stable addr/wdata/be/we until dmem_gnt.
    - STORE with gnt: the access completes; stay in IDLE.
    - LOAD with gnt: go to LOAD_WAIT.
  - LOAD_WAIT: dmem_req=0. On dmem_rvalid, register the formatted data into wb_load_data and go to LOAD_DONE.
  - LOAD_DONE: lsu_stall=0 for exactly one cycle, so EX/MEM advances and MEM/WB captures. Return to IDLE.
- lsu_stall = (IDLE & memop & ~fault & ~(store & dmem_gnt)) | LOAD_WAIT.
- Store formatting:
  - SB: wdata = {4{rs2[7:0]}}, be = 4'b0001<<off.
  - SH: wdata = {2{rs2[15:0]}}, be = 4'b0011<<off.
  - SW: wdata = rs2, be = 4'b1111.
- Load formatting:
  - s = dmem_rdata >> (8*off).
  - LB sign-extends s[7:0]; LBU zero-extends s[7:0].
  - LH sign-extends s[15:0]; LHU zero-extends s[15:0].
  - LW takes s unchanged.
  - Formatting uses the held mem_funct3/off; EX/MEM is stalled, so these are stable.
- wb_load_data holds its value until the next load capture.

## Timing
- Reset: state=IDLE and wb_load_data=0.
  - While rst=1, dmem_req, lsu_stall and lsu_fault are forced to 0.
- Store latency: completes in the gnt cycle; zero stall cycles if gnt arrives with req.
- Load latency: with gnt in cycle 0 and rvalid in cycle k≥1, stall covers cycles 0..k, LOAD_DONE is cycle k+1, and total cost is k+1 stall cycles.
- dmem_rvalid is never asserted in the same cycle as gnt.
  - An rvalid seen in IDLE or LOAD_DONE is ignored.
- Back-to-back memory ops: the next op's request starts in the cycle after the previous op completes.
- Reset mid-access returns to IDLE immediately; a late rvalid after reset is ignored.
- Non-memory ops: no request, no stall, all wb_* outputs pass through the same cycle.

## Test plan
- Reset: with a LOAD already presented at EX/MEM, assert rst → dmem_req=0, lsu_stall=0, wb_load_data=0.
- SB, addr 0x1003, rs2=0x000000A5, gnt in the same cycle →
  - dmem_addr=0x1000, be=4'b1000, wdata=0xA5A5A5A5, lsu_stall=0.
- LH, addr 0x2002, gnt after 2 cycles, rvalid 3 cycles later, rdata=0x8001_1234 →
  - lsu_stall high for 6 cycles, wb_load_data=0xFFFF8001 in LOAD_DONE.
- LBU, addr 0x2001, rdata=0x0000_F200 → wb_load_data=0x000000F2.
- LW at addr 0x3002 → lsu_fault=1, dmem_req=0, wb_reg_wr_en=0, lsu_stall=0.
- Reset asserted in LOAD_WAIT, then rvalid=1 two cycles after release → state stays IDLE, wb_load_data stays 0.
